// File: rtl/ai_accelerator_top.sv
// Wishbone-mapped matrix-multiply engine. It has a 64-word register/data window:
// words 0-5 are control and status, followed by A, B and C packed row-major.
module ai_accelerator_top #(
    parameter logic [31:0] CTRL_BASE = 32'h3200_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb,
    input  logic        wb_we_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack
);

    typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] mem [64];
    logic        busy, done, err;
    logic        served;
    logic [5:0]  i, j, k;
    logic [31:0] acc;

    // Address decode: the window is 256 bytes. The byte offset within a word is ignored.
    logic [31:0] off;
    logic        in_win, req, bus_go;
    logic [5:0]  n;
    logic        unused_ok;
    assign off       = wb_addr_i - CTRL_BASE;
    assign in_win    = (off[31:8] == 24'd0);
    assign n         = off[7:2];
    assign unused_ok = &{1'b0, off[1:0]};
    assign req       = wb_cyc_i & wb_stb & in_win;
    // Hold off the bus while the engine owns memory.
    // A request that has already been acked is not acked again until it drops.
    assign bus_go    = req & ~busy & ~served;

    // Shape decode. Only the low 3 bits of each dimension are used, and only after validation.
    logic [5:0] dim_wa, dim_ha, dim_wb, dim_hb;
    logic       shape_ok;
    assign dim_wa = {3'b0, mem[1][2:0]};
    assign dim_ha = {3'b0, mem[2][2:0]};
    assign dim_wb = {3'b0, mem[3][2:0]};
    assign dim_hb = {3'b0, mem[4][2:0]};

    function automatic logic dim_ok(input logic [31:0] d);
        return (d != 32'd0) && (d <= 32'd4);
    endfunction

    assign shape_ok = (mem[0] == 32'd1) && (mem[1] == mem[4]) &&
                      dim_ok(mem[1]) && dim_ok(mem[2]) && dim_ok(mem[3]) && dim_ok(mem[4]);

    // Operand and result word indices for the current (i, j, k).
    logic [5:0]  b_base, c_base, a_idx, b_idx, c_idx;
    logic [31:0] prod;
    assign b_base = 6'd6 + dim_ha * dim_wa;
    assign c_base = b_base + dim_hb * dim_wb;
    assign a_idx  = 6'd6 + i * dim_wa + k;
    assign b_idx  = b_base + k * dim_wb + j;
    assign c_idx  = c_base + i * dim_wb + j;
    assign prod   = $signed(mem[a_idx][15:0]) * $signed(mem[b_idx][15:0]);

    logic mac_en, store_en, fin, start_ok, start_bad;
    logic last_k, last_elem;
    assign last_k    = (k == dim_wa - 6'd1);
    assign last_elem = (i == dim_ha - 6'd1) && (j == dim_wb - 6'd1);

    // Engine state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Engine next-state and per-state strobes
    always_comb begin
        state_d   = state_q;
        mac_en    = 1'b0;
        store_en  = 1'b0;
        fin       = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state_q)
            IDLE: if (busy) begin
                if (shape_ok) begin
                    start_ok = 1'b1;
                    state_d  = MAC;
                end else begin
                    start_bad = 1'b1;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_k) state_d = STORE;
            end
            STORE: begin
                store_en = 1'b1;
                state_d  = last_elem ? DONE : MAC;
            end
            DONE: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Loop counters and accumulator. The accumulator is cleared on every entry to MAC.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            i <= '0; j <= '0; k <= '0; acc <= '0;
        end else if (start_ok) begin
            i <= '0; j <= '0; k <= '0; acc <= '0;
        end else if (mac_en) begin
            acc <= acc + prod;
            k   <= last_k ? 6'd0 : k + 6'd1;
        end else if (store_en) begin
            acc <= '0;
            if (j == dim_wb - 6'd1) begin
                j <= '0;
                i <= i + 6'd1;
            end else begin
                j <= j + 6'd1;
            end
        end
    end

    // Memory, status flags and the bus handshake. Bus and engine never write in the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int w = 0; w < 64; w++) mem[w] <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            served    <= 1'b0;
            wb_ack    <= 1'b0;
            wb_data_o <= '0;
        end else begin
            wb_ack    <= 1'b0;
            wb_data_o <= '0;
            if (!req) served <= 1'b0;
            if (bus_go) begin
                wb_ack <= 1'b1;
                served <= 1'b1;
                if (wb_we_i) begin
                    if (n == 6'd5) begin
                        busy <= 1'b1;
                        done <= 1'b0;
                        err  <= 1'b0;
                    end else begin
                        mem[n] <= wb_data_i;
                    end
                end else begin
                    wb_data_o <= (n == 6'd5) ? {29'b0, err, done, busy} : mem[n];
                end
            end
            if (start_bad) begin
                err  <= 1'b1;
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (store_en) mem[c_idx] <= acc;
            if (fin) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ai_accelerator_top.sv
// Directed bench for ai_accelerator_top. Expected read data is queued when a read is issued.
// Each queued value is checked when the matching ack arrives.
module tb_ai_accelerator_top;

    localparam logic [31:0] BASE = 32'h3200_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ack;

    always #5 clk = ~clk;

    ai_accelerator_top #(.CTRL_BASE(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_cyc_i (cyc),
        .wb_stb   (stb),
        .wb_we_i  (we),
        .wb_addr_i(addr),
        .wb_data_i(wdata),
        .wb_data_o(rdata),
        .wb_ack   (ack)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    string       cur_tag;
    int          last_wait;
    logic        last_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A single bus transfer. It waits up to 'budget' cycles for ack.
    // If ack arrives, it then checks that exactly one ack was given.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int budget);
        int cnt;
        cnt = 0;
        last_ack = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
        while (!last_ack && cnt < budget) begin
            @(negedge clk);
            cnt++;
            if (ack) begin
                last_ack = 1'b1;
                if (!w && exp_q.size() > 0) chk(cur_tag, rdata, exp_q.pop_front());
            end
        end
        last_wait = cnt;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (last_ack) begin
            @(negedge clk);
            chk({cur_tag, "_one_ack"}, {31'b0, ack}, 32'd0);
        end
    endtask

    task automatic wr(input logic [5:0] n, input logic [31:0] d);
        cur_tag = $sformatf("wr%0d", n);
        xfer(1'b1, BASE + {24'b0, n, 2'b00}, d, 20);
        chk({cur_tag, "_ack"}, {31'b0, last_ack}, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [5:0] n, input logic [31:0] exp, input int budget);
        cur_tag = tag;
        exp_q.push_back(exp);
        xfer(1'b0, BASE + {24'b0, n, 2'b00}, 32'd0, budget);
        if (!last_ack) begin
            chk({tag, "_ack"}, {31'b0, last_ack}, 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_data", rdata, 32'd0);
        rst_n = 1'b1;
        rd("rst_status", 6'd5, 32'd0, 20);
        rd("rst_w0", 6'd0, 32'd0, 20);

        // Register readback
        wr(0, 32'd1); wr(1, 32'd2); wr(2, 32'd2); wr(3, 32'd2); wr(4, 32'd2);
        rd("rb_op", 0, 32'd1, 20);
        rd("rb_wa", 1, 32'd2, 20);
        rd("rb_ha", 2, 32'd2, 20);
        rd("rb_wb", 3, 32'd2, 20);
        rd("rb_hb", 4, 32'd2, 20);

        // Low address bits are ignored
        cur_tag = "byte_off";
        exp_q.push_back(32'd2);
        xfer(1'b0, BASE + 32'd5, 32'd0, 20);
        chk("byte_off_ack", {31'b0, last_ack}, 32'd1);

        // 2x2 multiply. B[0][0] carries junk in the upper half, which the engine must ignore.
        wr(6, -32'sd3);  wr(7, -32'sd15); wr(8, -32'sd6);  wr(9, 32'd7);
        wr(10, 32'h1234_0009); wr(11, -32'sd15); wr(12, -32'sd2); wr(13, -32'sd5);
        wr(5, 32'hDEAD_BEEF);
        rd("c00_stalled", 14, 32'd3, 60);
        chk("stall_delay", {31'b0, (last_wait >= 8)}, 32'd1);
        rd("st_done", 5, 32'd2, 20);
        rd("c01", 15, 32'd120, 20);
        rd("c10", 16, -32'sd68, 20);
        rd("c11", 17, 32'd55, 20);
        rd("b00_kept", 10, 32'h1234_0009, 20);

        // Bad shape: WA != HB
        wr(1, 32'd3);
        wr(5, 32'd0);
        rd("st_bad", 5, 32'd6, 20);
        chk("bad_fast", {31'b0, (last_wait <= 2)}, 32'd1);
        rd("bad_c00", 14, 32'd3, 20);
        rd("bad_c01", 15, 32'd120, 20);
        rd("bad_c10", 16, -32'sd68, 20);
        rd("bad_c11", 17, 32'd55, 20);

        // Bad op
        wr(1, 32'd2); wr(0, 32'd2);
        wr(5, 32'd0);
        rd("st_badop", 5, 32'd6, 20);

        // Out-of-window accesses give no ack and do not alias into the window.
        cur_tag = "oow_wr";
        xfer(1'b1, BASE + 32'd256, 32'hA5A5_A5A5, 6);
        chk("oow_wr_noack", {31'b0, last_ack}, 32'd0);
        cur_tag = "oow_rd";
        xfer(1'b0, BASE + 32'd256, 32'd0, 6);
        chk("oow_rd_noack", {31'b0, last_ack}, 32'd0);
        rd("oow_w0", 0, 32'd2, 20);

        // 4x4 identity times 1..16
        wr(0, 32'd1); wr(1, 32'd4); wr(2, 32'd4); wr(3, 32'd4); wr(4, 32'd4);
        for (int r = 0; r < 16; r++) begin
            wr(6'(6 + r), (r % 5 == 0) ? 32'd1 : 32'd0);
            wr(6'(22 + r), 32'(r + 1));
        end
        wr(5, 32'd1);
        rd("id_c0", 38, 32'd1, 150);
        chk("id_latency", {31'b0, (last_wait >= 78 && last_wait <= 86)}, 32'd1);
        for (int r = 1; r < 16; r++)
            rd($sformatf("id_c%0d", r), 6'(38 + r), 32'(r + 1), 20);
        rd("id_st", 5, 32'd2, 20);
        rd("id_a_kept", 11, 32'd1, 20);
        rd("id_b_kept", 37, 32'd16, 20);

        // Reset in the middle of a computation
        wr(5, 32'd1);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack", {31'b0, ack}, 32'd0);
        chk("mid_rst_data", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("mid_rst_st", 5, 32'd0, 20);
        for (int w = 0; w < 64; w++)
            if (w != 5) rd($sformatf("clr_w%0d", w), 6'(w), 32'd0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
